// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a pending-write scoreboard.
//   Two combinational read ports, two clocked write ports (A = WB-ALU,
//   B = WB-load) and one busy bit per register for the hazard unit.
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   ra1/ra2 -> rd1/rd2   read address -> read data (combinational)
//   rbusy1/rbusy2        read register has a pending producer
//   we3/wa3/wd3          write port A
//   we4/wa4/wd4          write port B (wins over A on same address)
//   issue_en/issue_wa    destination of instruction issued this cycle
// Parameters: DATA_W, ADDR_W (depth 2**ADDR_W), ZERO_REG (r0 hardwired 0),
//   BYPASS (same-cycle write data forwarded to read ports).

// One read port: mux plus optional write forwarding and busy masking.
module regfile_mp_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                      ra,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs,
    input  logic [(1<<ADDR_W)-1:0]                 busy,
    input  logic                                   we3,
    input  logic [ADDR_W-1:0]                      wa3,
    input  logic [DATA_W-1:0]                      wd3,
    input  logic                                   we4,
    input  logic [ADDR_W-1:0]                      wa4,
    input  logic [DATA_W-1:0]                      wd4,
    output logic [DATA_W-1:0]                      rd,
    output logic                                   rbusy
);
    logic zero, hit3, hit4;

    assign zero = (ZERO_REG != 0) && (ra == '0);
    assign hit4 = (BYPASS != 0) && we4 && (wa4 == ra);
    assign hit3 = (BYPASS != 0) && we3 && (wa3 == ra);

    always_comb begin
        rd    = regs[ra];
        rbusy = busy[ra];
        if (zero) begin
            rd    = '0;
            rbusy = 1'b0;
        end else if (hit4) begin
            // port B is the younger producer, so it wins the forward
            rd    = wd4;
            rbusy = 1'b0;
        end else if (hit3) begin
            rd    = wd3;
            rbusy = 1'b0;
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_wa
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy, busy_nxt;
    logic                         wen3, wen4;

    logic [1:0][ADDR_W-1:0] ra_v;
    logic [1:0][DATA_W-1:0] rd_v;
    logic [1:0]             rbusy_v;

    // writes to r0 are dropped when it is hardwired
    assign wen3 = we3 && !((ZERO_REG != 0) && (wa3 == '0));
    assign wen4 = we4 && !((ZERO_REG != 0) && (wa4 == '0));

    // port B is assigned last so it wins a same-address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            if (wen3) regs[wa3] <= wd3;
            if (wen4) regs[wa4] <= wd4;
        end
    end

    // scoreboard: set on issue, clear on retiring write, set wins
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            logic set, clr;
            set = issue_en && (issue_wa == ADDR_W'(i));
            clr = (we3 && (wa3 == ADDR_W'(i))) || (we4 && (wa4 == ADDR_W'(i)));
            busy_nxt[i] = set || (busy[i] && !clr);
        end
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    assign ra_v   = {ra2, ra1};
    assign rd1    = rd_v[0];
    assign rd2    = rd_v[1];
    assign rbusy1 = rbusy_v[0];
    assign rbusy2 = rbusy_v[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .ra(ra_v[p]), .regs(regs), .busy(busy),
            .we3(we3), .wa3(wa3), .wd3(wd3),
            .we4(we4), .wa4(wa4), .wd4(wd4),
            .rd(rd_v[p]), .rbusy(rbusy_v[p])
        );
    end
endmodule
